// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder.
// Store size codes, load funct3 codes, FSM states and a size helper.
package dmem_responder_pkg;

    localparam logic [1:0] WRITE_IDLE = 2'b00;
    localparam logic [1:0] WRITE_BYTE = 2'b01;
    localparam logic [1:0] WRITE_HALF = 2'b10;
    localparam logic [1:0] WRITE_WORD = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        IDLE_S = 1'b0,
        RESP_S = 1'b1
    } state_e;

    // Access size of a load in WRITE_* terms; WRITE_IDLE marks an illegal funct3
    function automatic logic [1:0] load_size(input logic [2:0] f3);
        logic [1:0] sz;
        sz = WRITE_IDLE;
        case (f3)
            F3_LB, F3_LBU: sz = WRITE_BYTE;
            F3_LH, F3_LHU: sz = WRITE_HALF;
            F3_LW:         sz = WRITE_WORD;
            default:       sz = WRITE_IDLE;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/dmem_lane_ext.sv
// Lane select and sign/zero extension of a 32-bit memory word.
// Pure combinational; shared with the future data cache.
module dmem_lane_ext
    import dmem_responder_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    // Shift the addressed lane down, then extend by load type
    always_comb begin
        shifted = word >> {off, 3'b000};
        data    = '0;
        case (funct3)
            F3_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LW:   data = word;
            F3_LBU:  data = {24'b0, shifted[7:0]};
            F3_LHU:  data = {16'b0, shifted[15:0]};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM, lane-steered stores, extended loads.
// Define DMEM_MISALIGN_CHK_EN to flag misaligned half/word accesses.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_read,
    input  logic [1:0]  req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    logic [31:0] ram [DEPTH];

    state_e      state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [AW-1:0] idx;
    logic [1:0]    off_raw;
    logic [1:0]    off;
    logic [1:0]    size;
    logic          rw_err;
    logic          f3_err;
    logic          mis_err;
    logic          req_err;
    logic          accept;
    logic          we;
    logic [3:0]    be;
    logic [31:0]   wlane;
    logic [31:0]   rd_word;
    logic [31:0]   ext_data;
    logic [31:0]   load_data;
    logic          unused_addr;

    assign idx         = req_addr[AW+1:2];
    assign off_raw     = req_addr[1:0];
    assign unused_addr = ^req_addr[31:AW+2];

    assign req_ready = (state_q == IDLE_S) && rst_n;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_q == RESP_S);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // Decode access size, effective lane offset and error conditions
    always_comb begin
        size   = req_read ? load_size(req_funct3) : req_write;
        rw_err = req_read && (req_write != WRITE_IDLE);
        f3_err = req_read && (load_size(req_funct3) == WRITE_IDLE);
`ifdef DMEM_MISALIGN_CHK_EN
        off     = off_raw;
        mis_err = ((size == WRITE_HALF) && off_raw[0])
               || ((size == WRITE_WORD) && (off_raw != 2'b00));
`else
        off     = off_raw;
        mis_err = 1'b0;
        if (size == WRITE_HALF) off = {off_raw[1], 1'b0};
        if (size == WRITE_WORD) off = 2'b00;
`endif
        req_err = rw_err || f3_err || mis_err;
    end

    // Byte enables and store data replicated onto every lane
    always_comb begin
        be    = 4'b0000;
        wlane = req_wdata;
        case (req_write)
            WRITE_BYTE: begin
                be    = 4'b0001 << off;
                wlane = {4{req_wdata[7:0]}};
            end
            WRITE_HALF: begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                wlane = {2{req_wdata[15:0]}};
            end
            WRITE_WORD: be = 4'b1111;
            default:    be = 4'b0000;
        endcase
        we = accept && !req_read
          && (req_write != WRITE_IDLE) && !req_err;
    end

    // Store commit on the accept edge, only the enabled lanes
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) ram[idx][8*b +: 8] <= wlane[8*b +: 8];
            end
        end
    end

    assign rd_word = ram[idx];

    dmem_lane_ext u_lane_ext (
        .word   (rd_word),
        .off    (off),
        .funct3 (req_funct3),
        .data   (ext_data)
    );

    assign load_data = (req_read && !req_err) ? ext_data : 32'b0;

    // State and response registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE_S;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next state: capture response on accept, release on rsp_ready
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE_S: begin
                if (accept) begin
                    state_d = RESP_S;
                    rdata_d = load_data;
                    err_d   = req_err;
                end
            end
            RESP_S: begin
                if (rsp_ready) begin
                    state_d = IDLE_S;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE_S;
        endcase
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder with a byte-array reference model.
// Honours DMEM_MISALIGN_CHK_EN to pick misalignment expectations.
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int BYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_read = 1'b0;
    logic [1:0]  req_write = 2'b00;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] mem_m [BYTES];

    dmem_responder #(.DEPTH(DEPTH), .AW(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_read   (req_read),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    // Reference: byte-addressed memory, little endian, RV load/store rules
    task automatic model(input logic rd, input logic [1:0] wr,
                         input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd,
                         output logic [31:0] ed, output logic ee);
        int a;
        int sz;
        bit sgn;
        logic [31:0] v;
        a = int'(addr % BYTES);
        ed = '0;
        ee = 1'b0;
        sz = 0;
        sgn = 0;
        if (rd && wr != 2'b00) begin
            ee = 1'b1;
            return;
        end
        if (rd) begin
            case (f3)
                3'd0: begin sz = 1; sgn = 1; end
                3'd1: begin sz = 2; sgn = 1; end
                3'd2: sz = 4;
                3'd4: sz = 1;
                3'd5: sz = 2;
                default: begin ee = 1'b1; return; end
            endcase
        end else if (wr == 2'b00) begin
            return;
        end else begin
            sz = (wr == 2'b01) ? 1 : (wr == 2'b10) ? 2 : 4;
        end
        if (a % sz != 0) begin
`ifdef DMEM_MISALIGN_CHK_EN
            ee = 1'b1;
            return;
`else
            a = a - (a % sz);
`endif
        end
        if (rd) begin
            v = '0;
            for (int i = 0; i < sz; i++)
                v = v | (32'(mem_m[a+i]) << (8*i));
            if (sgn && v[8*sz-1])
                for (int i = 8*sz; i < 32; i++) v[i] = 1'b1;
            ed = v;
        end else begin
            for (int i = 0; i < sz; i++) begin
                v = wd >> (8*i);
                mem_m[a+i] = v[7:0];
            end
        end
    endtask

    // One full request/response transaction plus model update
    task automatic run(input logic rd, input logic [1:0] wr,
                       input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd,
                       output logic [31:0] gd, output logic ge,
                       output logic gv, output logic grdy,
                       output logic [31:0] ed, output logic ee);
        model(rd, wr, f3, addr, wd, ed, ee);
        req_read = rd;
        req_write = wr;
        req_funct3 = f3;
        req_addr = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        #1;
        grdy = req_ready;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        gv = rsp_valid;
        gd = rsp_rdata;
        ge = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b rdata=%h err=%b want 0/0/0",
                     rsp_valid, rsp_rdata, rsp_err);
        end
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_low: got %b want 0", req_ready);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_high: got %b want 1", req_ready);
        end
    endtask

    task automatic test_init();
        logic [31:0] gd, ed;
        logic ge, gv, gr, ee;
        for (int w = 0; w < 32; w++) begin
            run(1'b0, 2'b11, 3'b000, 32'(w*4), 32'h0, gd, ge, gv, gr, ed, ee);
            n_checks++;
            if (ge !== 1'b0 || gv !== 1'b1 || gr !== 1'b1) begin
                n_fail++;
                $display("FAIL init_sw[%0d]: err=%b valid=%b ready=%b want 0/1/1",
                         w, ge, gv, gr);
            end
        end
    endtask

    task automatic test_word();
        logic [31:0] gd, ed;
        logic ge, gv, gr, ee;
        run(1'b0, 2'b11, 3'b000, 32'h10, 32'hDEADBEEF, gd, ge, gv, gr, ed, ee);
        n_checks++;
        if (gd !== 32'h0 || ge !== 1'b0) begin
            n_fail++;
            $display("FAIL sw_rsp: rdata=%h err=%b want 0/0", gd, ge);
        end
        run(1'b1, 2'b00, 3'b010, 32'h10, 32'h0, gd, ge, gv, gr, ed, ee);
        n_checks++;
        if (gv !== 1'b1 || gd !== 32'hDEADBEEF || ge !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_basic: valid=%b rdata=%h err=%b want 1/deadbeef/0",
                     gv, gd, ge);
        end
    endtask

    task automatic test_byte();
        logic [31:0] gd, ed;
        logic ge, gv, gr, ee;
        run(1'b0, 2'b11, 3'b000, 32'h10, 32'h0, gd, ge, gv, gr, ed, ee);
        run(1'b0, 2'b01, 3'b000, 32'h13, 32'h80, gd, ge, gv, gr, ed, ee);
        run(1'b1, 2'b00, 3'b000, 32'h13, 32'h0, gd, ge, gv, gr, ed, ee);
        n_checks++;
        if (gd !== 32'hFFFFFF80 || ge !== 1'b0) begin
            n_fail++;
            $display("FAIL lb_sign: rdata=%h err=%b want ffffff80/0", gd, ge);
        end
        run(1'b1, 2'b00, 3'b100, 32'h13, 32'h0, gd, ge, gv, gr, ed, ee);
        n_checks++;
        if (gd !== 32'h00000080) begin
            n_fail++;
            $display("FAIL lbu_zero: rdata=%h want 00000080", gd);
        end
        run(1'b1, 2'b00, 3'b010, 32'h10, 32'h0, gd, ge, gv, gr, ed, ee);
        n_checks++;
        if (gd !== 32'h80000000) begin
            n_fail++;
            $display("FAIL sb_lane: rdata=%h want 80000000", gd);
        end
    endtask

    task automatic test_half();
        logic [31:0] gd, ed;
        logic ge, gv, gr, ee;
        run(1'b0, 2'b10, 3'b000, 32'h22, 32'hABCD1234, gd, ge, gv, gr, ed, ee);
        run(1'b1, 2'b00, 3'b101, 32'h22, 32'h0, gd, ge, gv, gr, ed, ee);
        n_checks++;
        if (gd !== 32'h00001234 || ge !== 1'b0) begin
            n_fail++;
            $display("FAIL lhu_upper: rdata=%h err=%b want 00001234/0", gd, ge);
        end
        run(1'b1, 2'b00, 3'b001, 32'h20, 32'h0, gd, ge, gv, gr, ed, ee);
        n_checks++;
        if (gd !== 32'h00000000) begin
            n_fail++;
            $display("FAIL lh_lower: rdata=%h want 00000000", gd);
        end
        run(1'b1, 2'b00, 3'b010, 32'h20, 32'h0, gd, ge, gv, gr, ed, ee);
        n_checks++;
        if (gd !== 32'h12340000) begin
            n_fail++;
            $display("FAIL sh_word: rdata=%h want 12340000", gd);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] gd, ed;
        logic ge, gv, gr, ee;
        run(1'b0, 2'b11, 3'b000, 32'h54, 32'h11111111, gd, ge, gv, gr, ed, ee);
        run(1'b1, 2'b00, 3'b010, 32'h11, 32'h0, gd, ge, gv, gr, ed, ee);
`ifdef DMEM_MISALIGN_CHK_EN
        n_checks++;
        if (gd !== 32'h0 || ge !== 1'b1) begin
            n_fail++;
            $display("FAIL lw_misalign: rdata=%h err=%b want 0/1", gd, ge);
        end
`else
        n_checks++;
        if (gd !== 32'h80000000 || ge !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_misalign: rdata=%h err=%b want 80000000/0", gd, ge);
        end
`endif
        run(1'b0, 2'b11, 3'b000, 32'h55, 32'hAAAA5555, gd, ge, gv, gr, ed, ee);
        n_checks++;
        if (ge !== ee) begin
            n_fail++;
            $display("FAIL sw_misalign_err: err=%b want %b", ge, ee);
        end
        run(1'b1, 2'b00, 3'b010, 32'h54, 32'h0, gd, ge, gv, gr, ed, ee);
`ifdef DMEM_MISALIGN_CHK_EN
        n_checks++;
        if (gd !== 32'h11111111) begin
            n_fail++;
            $display("FAIL sw_misalign_mem: rdata=%h want 11111111", gd);
        end
`else
        n_checks++;
        if (gd !== 32'hAAAA5555) begin
            n_fail++;
            $display("FAIL sw_misalign_mem: rdata=%h want aaaa5555", gd);
        end
`endif
    endtask

    task automatic test_stall();
        logic [31:0] gd, ed;
        logic ge, gv, gr, ee;
        model(1'b1, 2'b00, 3'b010, 32'h10, 32'h0, ed, ee);
        req_read = 1'b1;
        req_write = 2'b00;
        req_funct3 = 3'b010;
        req_addr = 32'h10;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== ed || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: valid=%b rdata=%h ready=%b want 1/%h/0",
                         c, rsp_valid, rsp_rdata, req_ready, ed);
            end
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: valid=%b ready=%b want 0/1",
                     rsp_valid, req_ready);
        end
        run(1'b1, 2'b00, 3'b100, 32'h13, 32'h0, gd, ge, gv, gr, ed, ee);
        n_checks++;
        if (gr !== 1'b1 || gv !== 1'b1 || gd !== ed) begin
            n_fail++;
            $display("FAIL stall_next: ready=%b valid=%b rdata=%h want 1/1/%h",
                     gr, gv, gd, ed);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] gd, ed;
        logic ge, gv, gr, ee;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                model(1'b1, 2'b00, 3'b010, 32'h10, 32'h0, ed, ee);
                req_read = 1'b1;
                req_write = 2'b00;
            end else begin
                model(1'b0, 2'b11, 3'b000, 32'h30, 32'h77665544, ed, ee);
                req_read = 1'b0;
                req_write = 2'b11;
            end
            req_funct3 = 3'b010;
            req_addr = (k == 0) ? 32'h10 : 32'h30;
            req_wdata = 32'h77665544;
            req_valid = 1'b1;
            rsp_ready = 1'b0;
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            rst_n = 1'b0;
            @(posedge clk);
            #1;
            n_checks++;
            if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid[%0d]: valid=%b rdata=%h err=%b want 0/0/0",
                         k, rsp_valid, rsp_rdata, rsp_err);
            end
            rst_n = 1'b1;
            #1;
            n_checks++;
            if (req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_mid_ready[%0d]: got %b want 1", k, req_ready);
            end
        end
        run(1'b1, 2'b00, 3'b010, 32'h30, 32'h0, gd, ge, gv, gr, ed, ee);
        n_checks++;
        if (gd !== 32'h77665544) begin
            n_fail++;
            $display("FAIL reset_keeps_store: rdata=%h want 77665544", gd);
        end
    endtask

    task automatic test_alias_illegal();
        logic [31:0] gd, ed;
        logic ge, gv, gr, ee;
        run(1'b0, 2'b11, 3'b000, 32'h1010, 32'hCAFEF00D, gd, ge, gv, gr, ed, ee);
        run(1'b1, 2'b00, 3'b010, 32'h0010, 32'h0, gd, ge, gv, gr, ed, ee);
        n_checks++;
        if (gd !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL alias: rdata=%h want cafef00d", gd);
        end
        run(1'b1, 2'b11, 3'b010, 32'h10, 32'h01020304, gd, ge, gv, gr, ed, ee);
        n_checks++;
        if (ge !== 1'b1 || gd !== 32'h0) begin
            n_fail++;
            $display("FAIL rd_wr_err: err=%b rdata=%h want 1/0", ge, gd);
        end
        run(1'b1, 2'b00, 3'b010, 32'h10, 32'h0, gd, ge, gv, gr, ed, ee);
        n_checks++;
        if (gd !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL rd_wr_nowrite: rdata=%h want cafef00d", gd);
        end
        for (int f = 3; f < 8; f++) begin
            if (f == 4 || f == 5) continue;
            run(1'b1, 2'b00, 3'(f), 32'h10, 32'h0, gd, ge, gv, gr, ed, ee);
            n_checks++;
            if (ge !== 1'b1 || gd !== 32'h0) begin
                n_fail++;
                $display("FAIL bad_f3[%0d]: err=%b rdata=%h want 1/0", f, ge, gd);
            end
        end
        run(1'b0, 2'b00, 3'b010, 32'h10, 32'h0, gd, ge, gv, gr, ed, ee);
        n_checks++;
        if (gv !== 1'b1 || ge !== 1'b0 || gd !== 32'h0) begin
            n_fail++;
            $display("FAIL noop: valid=%b err=%b rdata=%h want 1/0/0", gv, ge, gd);
        end
    endtask

    task automatic test_random();
        logic [31:0] gd, ed, addr;
        logic ge, gv, gr, ee, rd;
        logic [1:0] wr;
        logic [2:0] f3;
        for (int n = 0; n < 300; n++) begin
            rd = 1'($urandom_range(0, 1));
            wr = 2'($urandom_range(0, 3));
            if (rd && ($urandom_range(0, 7) != 0)) wr = 2'b00;
            f3 = 3'($urandom_range(0, 7));
            addr = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 127));
            run(rd, wr, f3, addr, $urandom, gd, ge, gv, gr, ed, ee);
            n_checks++;
            if (gr !== 1'b1 || gv !== 1'b1 || gd !== ed || ge !== ee) begin
                n_fail++;
                $display("FAIL rand[%0d] rd=%b wr=%b f3=%0d a=%h: rdy=%b v=%b d=%h e=%b want 1/1/%h/%b",
                         n, rd, wr, f3, addr, gr, gv, gd, ge, ed, ee);
            end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_word();
        test_byte();
        test_half();
        test_misalign();
        test_stall();
        test_reset_mid();
        test_alias_illegal();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
